rgb888_to_ycbcr422: RTL and testbench

Pipelined colour-space converter between the pattern/frame source and the 16-bit HDMI data bus of the ADV7511 transmitter. It accepts one RGB888 pixel per pixel clock with its DE/HSYNC/VSYNC and converts to BT.601 limited-range YCbCr. It subsamples chroma to 4:2:2 and emits the pixel together with the sync and DE signals, all delayed by the same fixed latency. Its outputs drive the transmitter data pins and the hsync/vsync/de pins directly.

---
 rtl/rgb888_to_ycbcr422_if.sv | 24 ++
 rtl/rgb888_to_ycbcr422.sv | 109 ++++++++++
 tb/tb_rgb888_to_ycbcr422.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rgb888_to_ycbcr422_if.sv
// Video bus between the pixel source, the colour converter and the ADV7511 pins.
// Signal names match the original converter ports.
interface rgb888_to_ycbcr422_if;
  logic        in_de;
  logic        in_hsync;
  logic        in_vsync;
  logic [7:0]  in_r;
  logic [7:0]  in_g;
  logic [7:0]  in_b;
  logic        out_de;
  logic        out_hsync;
  logic        out_vsync;
  logic [15:0] color_out;

  modport master (
    output in_de, in_hsync, in_vsync, in_r, in_g, in_b,
    input  out_de, out_hsync, out_vsync, color_out
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, in_r, in_g, in_b,
    output out_de, out_hsync, out_vsync, color_out
  );
endinterface

// File: rtl/rgb888_to_ycbcr422.sv
// RGB888 -> BT.601 limited-range YCbCr 4:2:2. Five register stages;
// DE/HSYNC/VSYNC travel alongside the pixel in a matching shift register.
module rgb888_to_ycbcr422 #(
  parameter bit CHROMA_AVG = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  reset,
  rgb888_to_ycbcr422_if.slave   vid
);

  typedef logic signed [17:0] s18_t;

  function automatic logic [7:0] clamp(input s18_t v, input s18_t lo, input s18_t hi);
    if (v < lo)      return 8'(lo);
    else if (v > hi) return 8'(hi);
    else             return 8'(v);
  endfunction

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  // ctl[i] = {vsync, hsync, de} at stage i+1; ctl[2] is S3, ctl[3] is S4, ctl[4] drives the pins
  logic [2:0]  ctl [5];

  logic [7:0]  r1, g1, b1;
  s18_t        p_yr, p_yg, p_yb, p_br, p_bg, p_bb, p_rr, p_rg, p_rb;
  s18_t        sum_y, sum_cb, sum_cr;
  logic [7:0]  y3, cb3, cr3;
  logic [7:0]  y4, cb4, cr4;
  logic [7:0]  cr_prev;
  logic        phase;
  logic [7:0]  chroma;
  logic [15:0] color_q;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int unsigned i = 0; i < 5; i++) ctl[i] <= '0;
    end else begin
      ctl[0] <= {vid.in_vsync, vid.in_hsync, vid.in_de};
      for (int unsigned i = 1; i < 5; i++) ctl[i] <= ctl[i-1];
    end
  end

  always_comb begin
    sum_y  = p_yr + p_yg + p_yb + 18'sd128;
    sum_cb = p_bb - p_br - p_bg + 18'sd128;
    sum_cr = p_rr - p_rg - p_rb + 18'sd128;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r1 <= '0; g1 <= '0; b1 <= '0;
      p_yr <= '0; p_yg <= '0; p_yb <= '0;
      p_br <= '0; p_bg <= '0; p_bb <= '0;
      p_rr <= '0; p_rg <= '0; p_rb <= '0;
      y3 <= '0; cb3 <= '0; cr3 <= '0;
      y4 <= '0; cb4 <= '0; cr4 <= '0;
    end else begin
      r1 <= vid.in_r;
      g1 <= vid.in_g;
      b1 <= vid.in_b;
      // products kept as positive magnitudes; signs are applied in the sums
      p_yr <= $signed({10'd0, r1}) * 18'sd66;
      p_yg <= $signed({10'd0, g1}) * 18'sd129;
      p_yb <= $signed({10'd0, b1}) * 18'sd25;
      p_br <= $signed({10'd0, r1}) * 18'sd38;
      p_bg <= $signed({10'd0, g1}) * 18'sd74;
      p_bb <= $signed({10'd0, b1}) * 18'sd112;
      p_rr <= $signed({10'd0, r1}) * 18'sd112;
      p_rg <= $signed({10'd0, g1}) * 18'sd94;
      p_rb <= $signed({10'd0, b1}) * 18'sd18;
      y3  <= clamp(18'sd16  + (sum_y  >>> 8), 18'sd16, 18'sd235);
      cb3 <= clamp(18'sd128 + (sum_cb >>> 8), 18'sd16, 18'sd240);
      cr3 <= clamp(18'sd128 + (sum_cr >>> 8), 18'sd16, 18'sd240);
      y4  <= y3;
      cb4 <= cb3;
      cr4 <= cr3;
    end
  end

  // S4 holds pixel n while S3 already carries pixel n+1, giving the even pixel its partner
  always_comb begin
    chroma = cb4;
    if (!phase) begin
      if (CHROMA_AVG && ctl[2][0]) chroma = avg(cb4, cb3);
    end else begin
      chroma = CHROMA_AVG ? avg(cr_prev, cr4) : cr4;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      phase   <= 1'b0;
      cr_prev <= '0;
      color_q <= 16'h1080;
    end else begin
      phase   <= ctl[3][0] ? ~phase : 1'b0;
      cr_prev <= cr4;
      color_q <= ctl[3][0] ? {y4, chroma} : 16'h1080;
    end
  end

  assign vid.out_de    = ctl[4][0];
  assign vid.out_hsync = ctl[4][1];
  assign vid.out_vsync = ctl[4][2];
  assign vid.color_out = color_q;

endmodule

// File: tb/tb_rgb888_to_ycbcr422.sv
// Directed bench for rgb888_to_ycbcr422: one instance per CHROMA_AVG setting,
// both fed the same stimulus and checked against hand-computed values 5 cycles later.
`timescale 1ns/1ps
module tb_rgb888_to_ycbcr422;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #6 clk_in = ~clk_in;

  rgb888_to_ycbcr422_if va ();
  rgb888_to_ycbcr422_if vd ();

  rgb888_to_ycbcr422 #(.CHROMA_AVG(1'b1)) dut_avg  (.clk_in(clk_in), .reset(reset), .vid(va));
  rgb888_to_ycbcr422 #(.CHROMA_AVG(1'b0)) dut_drop (.clk_in(clk_in), .reset(reset), .vid(vd));

  typedef struct packed {
    logic        de, hs, vs, chk;
    logic [15:0] ca, cd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare(input exp_t e);
    check("de_avg",  16'(va.out_de),    16'(e.de));
    check("hs_avg",  16'(va.out_hsync), 16'(e.hs));
    check("vs_avg",  16'(va.out_vsync), 16'(e.vs));
    check("de_drop", 16'(vd.out_de),    16'(e.de));
    check("hs_drop", 16'(vd.out_hsync), 16'(e.hs));
    check("vs_drop", 16'(vd.out_vsync), 16'(e.vs));
    if (!e.de) begin
      check("blank_avg",  va.color_out, 16'h1080);
      check("blank_drop", vd.color_out, 16'h1080);
    end else if (e.chk) begin
      check("color_avg",  va.color_out, e.ca);
      check("color_drop", vd.color_out, e.cd);
    end
  endtask

  task automatic step(input logic rst, input logic de, input logic hs, input logic vs,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic chk, input logic [15:0] ca, input logic [15:0] cd);
    exp_t e;
    exp_t idle_e;
    idle_e = '{de: 1'b0, hs: 1'b0, vs: 1'b0, chk: 1'b1, ca: 16'h1080, cd: 16'h1080};
    reset = rst;
    va.in_de = de; va.in_hsync = hs; va.in_vsync = vs; va.in_r = r; va.in_g = g; va.in_b = b;
    vd.in_de = de; vd.in_hsync = hs; vd.in_vsync = vs; vd.in_r = r; vd.in_g = g; vd.in_b = b;
    @(posedge clk_in);
    #1;
    if (rst) begin
      q.delete();
      compare(idle_e);
    end else begin
      e = '{de: de, hs: hs, vs: vs, chk: chk, ca: ca, cd: cd};
      q.push_back(e);
      if (q.size() == 5) compare(q.pop_front());
      else compare(idle_e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 16'h1080, 16'h1080);
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [15:0] ca, input logic [15:0] cd);
    step(1'b0, 1'b1, 1'b0, 1'b0, r, g, b, 1'b1, ca, cd);
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1, 16'h1080, 16'h1080);
    idle(6);

    // white then black lines
    repeat (4) px(8'd255, 8'd255, 8'd255, 16'hEB80, 16'hEB80);
    idle(3);
    repeat (4) px(8'd0, 8'd0, 8'd0, 16'h1080, 16'h1080);
    idle(3);

    // pure red pair: Y=82 Cb=90 Cr=240
    px(8'd255, 8'd0, 8'd0, 16'h525A, 16'h525A);
    px(8'd255, 8'd0, 8'd0, 16'h52F0, 16'h52F0);
    idle(3);

    // red then white: averaged vs dropped chroma
    px(8'd255, 8'd0,   8'd0,   16'h526D, 16'h525A);
    px(8'd255, 8'd255, 8'd255, 16'hEBB8, 16'hEB80);
    idle(3);

    // odd-length line, then a line whose first pixel must be even again
    px(8'd255, 8'd0,   8'd0,   16'h525A, 16'h525A);
    px(8'd255, 8'd0,   8'd0,   16'h52F0, 16'h52F0);
    px(8'd255, 8'd255, 8'd255, 16'hEB80, 16'hEB80);
    idle(2);
    px(8'd255, 8'd255, 8'd255, 16'hEB6D, 16'hEB80);
    px(8'd255, 8'd0,   8'd0,   16'h52B8, 16'h52F0);
    idle(3);

    // one-pixel lines separated by a single blank cycle
    px(8'd255, 8'd0,   8'd0,   16'h525A, 16'h525A);
    idle(1);
    px(8'd255, 8'd255, 8'd255, 16'hEB80, 16'hEB80);
    idle(6);

    // reset at pixel 10 of a line; the source restarts afterwards
    for (int i = 0; i < 10; i++)
      px(8'd255, 8'd0, 8'd0, (i % 2 == 0) ? 16'h525A : 16'h52F0, (i % 2 == 0) ? 16'h525A : 16'h52F0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 8'd0, 1'b1, 16'h1080, 16'h1080);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      px(8'd255, 8'd255, 8'd255, 16'hEB6D, 16'hEB80);
      px(8'd255, 8'd0,   8'd0,   16'h52B8, 16'h52F0);
    end
    idle(6);

    // reduced raster (40 x 6, 24 active, hsync coincident with DE fall) for two frames
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < 6; l++)
        for (int c = 0; c < 40; c++)
          step(1'b0, (l >= 2) && (c < 24), (c >= 24) && (c < 28), (l < 2),
               8'($urandom_range(255)), 8'($urandom_range(255)), 8'($urandom_range(255)),
               1'b0, 16'h0000, 16'h0000);
    idle(6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
